fir_out_requant: RTL and testbench
==================================

Name: fir_out_requant

Overview:
- Stage directly downstream of the 11-tap symmetric FIR filter.
- Takes the full-precision filter output, rounds it, saturates it to the DAC/stream word width and optionally decimates it.
- Buffers the result in a small FIFO and delivers it over a valid/ready stream interface to the next consumer.

Parameters:
- N, 17: FIR input sample width; sets input width IN_W = 2*N+4 (38 by default). IN_W is derived and is not an independent parameter.
- OUT_W, 16: output sample width. Legal range 2..IN_W.
- SHIFT, 16: arithmetic right shift applied after rounding. The filter DC gain is 65408 (about 2^16), so the default gives close to unity gain. SHIFT=0 disables rounding.
- DECIM, 1: keep 1 of every DECIM accepted samples. Legal range 1..255.
- FIFO_DEPTH, 4: output buffer entries. Must be a power of two, at least 2.

Ports:
- clk, input, 1: sole clock; all state is on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_data holds a new filter output this cycle.
- in_data, input, IN_W: signed two's-complement filter output (yn).
- out_valid, input/output: output, 1: FIFO is non-empty.
- out_ready, input, 1: consumer accepts out_data this cycle.
- out_data, output, OUT_W: signed head of the FIFO.
- sat_flag, output, 1: registered; high for one cycle when a forwarded sample was clipped.
- drop_sticky, output, 1: set when a sample arrives while the FIFO is full; cleared only by rst.
- fifo_level, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- sat_count, output, 16: saturation event counter (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, sat_flag=0, drop_sticky=0, fifo_level=0, sat_count=0, decimation phase=0, all pipeline valid bits 0.
- Reset asserted mid-stream discards every in-flight and buffered sample immediately.
- Stage R (round), on a cycle with in_valid=1:
  - r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed at IN_W+1 bits so the addition cannot wrap.
  - This is round-half-up (toward +inf): +3.5 gives 4, -3.5 gives -3.
- Stage S (saturate/decimate), one cycle after R:
  - If r > 2^(OUT_W-1)-1, clip to that value; if r < -2^(OUT_W-1), clip to that value.
  - Phase counter runs 0..DECIM-1 and advances on every valid R result, wrapping to 0.
  - A sample is forwarded only when phase==0. Discarded phases produce no sat_flag and no sat_count update.
- Stage F (FIFO), one cycle after S:
  - A forwarded sample is pushed.
  - sat_flag pulses in the same cycle the push is attempted, whether or not the push succeeds.
- Latency: in_valid in cycle 0 makes out_valid=1 with the sample visible in cycle 3 when the FIFO was empty. Throughput is one sample per clock.
- Handshake:
  - A pop occurs when out_valid && out_ready.
  - out_data is stable while out_valid=1 && out_ready=0.
  - out_valid never depends combinationally on out_ready.
- FIFO boundary cases:
  - Push while empty: the entry is written; out_valid rises the next cycle. There is no fall-through.
  - Push and pop in the same cycle while full: both occur and the level is unchanged. The pop frees space first, so no drop occurs.
  - Push while full without a pop: the sample is discarded, drop_sticky is set and the level stays at FIFO_DEPTH.
  - Push and pop in the same cycle, not full: level is unchanged and ordering is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Pipeline stages R and S never stall. Backpressure is absorbed only by the FIFO; overflow is reported, never blocking.

Optional Feature:
- Macro: FIR_REQUANT_SAT_COUNT_EN.
- Defined: sat_count increments on every sat_flag pulse, holds at 16'hFFFF and resets to 0.
- Undefined: no counter logic is built and sat_count is tied to 0. The port list is identical in both builds.

Decomposition:
- Package fir_pkg:
  - FIR_N=17, FIR_OUT_W=2*FIR_N+4, REQ_OUT_W=16, REQ_SHIFT=16.
  - Function sat_clip(value, width).
  - Typedef of the signed filter-output word.
- One sub-module: req_sync_fifo (parameters WIDTH, DEPTH). It owns push, pop, level and full/empty.
- Rounding, saturation and decimation stay in the top module.

Test Plan (defaults unless noted):
- Rounding: in_data=229376 (3.5 x 2^16) gives out_data=4; 229375 gives 3; -229376 gives -3; each appears 3 cycles after in_valid.
- Saturation: in_data=40000x2^16 gives 32767 with a sat_flag pulse; -40000x2^16 gives -32768; with the macro on, sat_count=2.
- Backpressure: out_ready=0 and 6 back-to-back samples 1..6 (x2^16) give fifo_level=4 and drop_sticky=1. Then out_ready=1 drains 1,2,3,4 in order, and out_valid falls after 4.
- Full with simultaneous push/pop: FIFO full, out_ready=1 and a new sample pushed gives no drop, level stays 4 and order is preserved.
- Decimation, DECIM=3: samples 1..9 back-to-back give outputs 1,4,7 only.
- Reset mid-stream: level=3, rst pulsed asynchronously between edges makes out_valid=0 and fifo_level=0 at once. The first post-reset sample arrives after the 3-cycle latency.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, types and helpers for the FIR filter and its
// output requantiser.
//   FIR_N      : FIR input sample width
//   FIR_OUT_W  : full-precision filter output width (2*FIR_N+4)
//   REQ_OUT_W  : requantised output width
//   REQ_SHIFT  : default post-rounding right shift (filter DC gain ~2^16)
//   fir_word_t : signed full-precision filter output word
//   sat_clip() : clamp a signed value to the range of a signed 'width'-bit word
package fir_pkg;

  localparam int FIR_N     = 17;
  localparam int FIR_OUT_W = 2 * FIR_N + 4;
  localparam int REQ_OUT_W = 16;
  localparam int REQ_SHIFT = 16;

  typedef logic signed [FIR_OUT_W-1:0] fir_word_t;

  // Values are carried at 64 bits so the helper serves any width up to 63.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] value,
                                                  input int                 width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 << (width - 1)) - 64'sd1;
    lo = -(64'sd1 << (width - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

endpackage

// File: rtl/req_sync_fifo.sv
// req_sync_fifo: single-clock FIFO buffering requantised samples.
//   clk, rst  : clock, asynchronous active-high reset
//   push, din : write request and data (ignored when full without a pop)
//   ready     : consumer ready; a pop happens when ready && valid
//   dout      : head entry, forced to 0 while empty
//   valid     : FIFO non-empty
//   full      : level == DEPTH
//   level     : current occupancy
//   drop      : one-cycle pulse when a push was discarded
// A pop in the same cycle as a push into a full FIFO frees the slot first,
// so that push is accepted. There is no fall-through path from din to dout.
module req_sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic             drop
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop;
  logic             push_ok;

  assign valid   = (level != '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign pop     = valid && ready;
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign dout    = valid ? mem[rd_ptr] : '0;

  // NOTE: storage is deliberately left out of reset; the level counter and
  // the dout mux guarantee stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers are PTR_W bits wide, so they wrap modulo DEPTH on their own.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// fir_out_requant: rounds, saturates and optionally decimates the
// full-precision FIR output, then buffers it for a valid/ready consumer.
//   clk, rst    : clock, asynchronous active-high reset
//   in_valid    : in_data carries a new filter output
//   in_data     : signed filter output, IN_W = 2*N+4 bits
//   out_valid   : output FIFO non-empty
//   out_ready   : consumer takes out_data this cycle
//   out_data    : signed head of the FIFO (0 while empty)
//   sat_flag    : one-cycle pulse when a forwarded sample was clipped
//   drop_sticky : a forwarded sample met a full FIFO; cleared only by rst
//   fifo_level  : FIFO occupancy
//   sat_count   : saturating count of sat_flag pulses
// Pipeline: R (round) -> S (saturate/decimate) -> F (FIFO push). R and S
// never stall; a full FIFO drops samples instead of back-pressuring.
// Build option FIR_REQUANT_SAT_COUNT_EN: when defined, sat_count is a live
// counter; otherwise no counter is built and sat_count reads 0.
module fir_out_requant
  import fir_pkg::*;
#(
  parameter  int N          = FIR_N,
  parameter  int OUT_W      = REQ_OUT_W,
  parameter  int SHIFT      = REQ_SHIFT,
  parameter  int DECIM      = 1,
  parameter  int FIFO_DEPTH = 4,
  localparam int IN_W       = 2 * N + 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             sat_flag,
  output logic             drop_sticky,
  output logic [LVL_W-1:0] fifo_level,
  output logic [15:0]      sat_count
);

  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  // Half an LSB of the shifted result; zero when no shift is applied.
  localparam logic signed [IN_W:0] RND =
    (SHIFT > 0) ? ({{IN_W{1'b0}}, 1'b1} << RND_SH) : '0;

  // ---------------- Stage R: round (one extra bit so +RND cannot wrap)
  logic signed [IN_W:0] in_ext;
  logic signed [IN_W:0] r_next;
  logic signed [IN_W:0] r_data;
  logic                 r_valid;

  assign in_ext = {in_data[IN_W-1], in_data};
  assign r_next = (in_ext + RND) >>> SHIFT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_data <= r_next;
    end
  end

  // ---------------- Stage S: saturate and decimate
  logic signed [63:0] r_wide;
  logic signed [63:0] clipped;
  logic               clip_hit;
  logic [PH_W-1:0]    phase;
  logic [PH_W-1:0]    phase_next;
  logic               s_valid;
  logic               s_sat;
  logic [OUT_W-1:0]   s_data;

  assign r_wide     = 64'(r_data);
  assign clipped    = sat_clip(r_wide, OUT_W);
  assign clip_hit   = (clipped != r_wide);
  assign phase_next = (phase == PH_W'(DECIM - 1)) ? '0 : phase + 1'b1;

  // Discarded phases leave s_valid and s_sat low, so they never reach the
  // FIFO, sat_flag or sat_count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase   <= '0;
      s_valid <= 1'b0;
      s_sat   <= 1'b0;
      s_data  <= '0;
    end else begin
      s_valid <= 1'b0;
      s_sat   <= 1'b0;
      if (r_valid) begin
        phase <= phase_next;
        if (phase == '0) begin
          s_valid <= 1'b1;
          s_sat   <= clip_hit;
          s_data  <= clipped[OUT_W-1:0];
        end
      end
    end
  end

  // sat_flag is the registered clip bit and coincides with the push attempt.
  assign sat_flag = s_sat;

  // ---------------- Stage F: output FIFO
  logic fifo_drop;
  logic fifo_full;

  req_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid),
    .din   (s_data),
    .ready (out_ready),
    .dout  (out_data),
    .valid (out_valid),
    .full  (fifo_full),
    .level (fifo_level),
    .drop  (fifo_drop)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            drop_sticky <= 1'b0;
    else if (fifo_drop) drop_sticky <= 1'b1;
  end

`ifdef FIR_REQUANT_SAT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                sat_count <= '0;
    else if (sat_flag && sat_count != '1)   sat_count <= sat_count + 1'b1;
  end
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// tb_fir_out_requant: directed test of fir_out_requant with hand-computed
// expectations. A second instance with DECIM=3 covers decimation.
module tb_fir_out_requant;

  localparam int IN_W = 38;
  localparam longint U = 65536;  // 2^16: one output LSB at SHIFT=16

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   in_valid = 1'b0;
  logic [IN_W-1:0]        in_data = '0;
  logic                   out_ready = 1'b0;
  logic                   out_valid;
  logic signed [15:0]     out_data;
  logic                   sat_flag;
  logic                   drop_sticky;
  logic [2:0]             fifo_level;
  logic [15:0]            sat_count;

  logic                   d3_out_valid;
  logic signed [15:0]     d3_out_data;
  logic                   d3_sat_flag;
  logic                   d3_drop_sticky;
  logic [2:0]             d3_fifo_level;
  logic [15:0]            d3_sat_count;

  int total = 0;
  int bad   = 0;
  int sat_pulses = 0;
  longint d3_q[$];

  always #5 clk = ~clk;

  fir_out_requant dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .sat_flag    (sat_flag),
    .drop_sticky (drop_sticky),
    .fifo_level  (fifo_level),
    .sat_count   (sat_count)
  );

  fir_out_requant #(.DECIM(3)) dut_d3 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (d3_out_valid),
    .out_ready   (1'b1),
    .out_data    (d3_out_data),
    .sat_flag    (d3_sat_flag),
    .drop_sticky (d3_drop_sticky),
    .fifo_level  (d3_fifo_level),
    .sat_count   (d3_sat_count)
  );

  // Count sat_flag cycles and collect everything the DECIM=3 instance emits.
  always @(posedge clk) begin
    if (sat_flag)     sat_pulses++;
    if (d3_out_valid) d3_q.push_back(longint'(d3_out_data));
  end

  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input longint v);
    in_valid = 1'b1;
    in_data  = v[IN_W-1:0];
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One sample through an empty pipe: invisible at cycle 2, visible at 3.
  task automatic single(input string tag, input longint v, input longint exp);
    drive(v);
    tick();
    idle();
    tick();
    check({tag, "_early_valid"}, longint'(out_valid), 0);
    tick();
    check({tag, "_valid"}, longint'(out_valid), 1);
    check({tag, "_data"}, longint'(out_data), exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // ---- reset state
    #2;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_sat_flag", longint'(sat_flag), 0);
    check("rst_drop", longint'(drop_sticky), 0);
    check("rst_level", longint'(fifo_level), 0);
    check("rst_sat_count", longint'(sat_count), 0);
    do_reset();

    // ---- rounding: half-up
    single("rnd_p3p5", 229376, 4);
    single("rnd_p3m", 229375, 3);
    single("rnd_m3p5", -229376, -3);
    check("rnd_no_sat", longint'(sat_pulses), 0);

    // ---- saturation
    do_reset();
    sat_pulses = 0;
    single("sat_hi", 40000 * U, 32767);
    single("sat_lo", -40000 * U, -32768);
    tick(2);
    check("sat_pulses", longint'(sat_pulses), 2);
`ifdef FIR_REQUANT_SAT_COUNT_EN
    check("sat_count", longint'(sat_count), 2);
`else
    check("sat_count", longint'(sat_count), 0);
`endif

    // ---- backpressure and overflow
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      drive(i * U);
      tick();
    end
    idle();
    tick(4);
    check("bp_level", longint'(fifo_level), 4);
    check("bp_drop", longint'(drop_sticky), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("bp_drain%0d", i), longint'(out_data), i);
      tick();
    end
    check("bp_empty", longint'(out_valid), 0);
    out_ready = 1'b0;

    // ---- push and pop together while full
    do_reset();
    for (int i = 11; i <= 15; i++) begin
      drive(i * U);
      tick();
    end
    idle();
    tick();
    check("full_level", longint'(fifo_level), 4);
    out_ready = 1'b1;
    check("full_head", longint'(out_data), 11);
    tick();
    check("full_pp_level", longint'(fifo_level), 4);
    check("full_pp_drop", longint'(drop_sticky), 0);
    for (int i = 12; i <= 15; i++) begin
      check($sformatf("full_order%0d", i), longint'(out_data), i);
      tick();
    end
    check("full_empty", longint'(out_valid), 0);
    out_ready = 1'b0;

    // ---- decimation by 3
    do_reset();
    d3_q.delete();
    for (int i = 1; i <= 9; i++) begin
      drive(i * U);
      tick();
    end
    idle();
    tick(6);
    check("dec_count", longint'(d3_q.size()), 3);
    if (d3_q.size() == 3) begin
      check("dec_0", d3_q[0], 1);
      check("dec_1", d3_q[1], 4);
      check("dec_2", d3_q[2], 7);
    end

    // ---- asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b0;
    for (int i = 21; i <= 23; i++) begin
      drive(i * U);
      tick();
    end
    idle();
    tick(2);
    check("mid_level", longint'(fifo_level), 3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_level", longint'(fifo_level), 0);
    #1;
    rst = 1'b0;
    tick();
    single("post_rst", 30 * U, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #100000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
